msi_cpu_requester: RTL
======================

Name: msi_cpu_requester

Overview:
- CPU-side initiator of the MSI snooping protocol. It turns CPU reads and writes into bus operations (read_miss, write_miss, invalidate) and keeps per-line MSI state for a small direct-mapped cache.
- It also applies incoming snooped operations to its own line states.
- It sits between the CPU port and the shared snoop bus, facing the bus-side snoop state machines of the other caches.

Parameters:
- LINES, 4, number of cache lines; power of two, at least 2.
- ADDR_W, 8, block address width. Index = addr[log2(LINES)-1:0]; tag = remaining upper bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_valid  in  1  CPU request; held with rw/addr until cpu_ready
- cpu_rw  in  1  0=read, 1=write
- cpu_addr  in  ADDR_W  block address
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  valid with cpu_ready; 1 = completed without bus traffic
- bus_req  out  1  bus arbitration request
- bus_grant  in  1  arbiter grant
- bus_valid  out  1  one-cycle bus operation strobe
- bus_op  out  2  00 read_miss, 01 write_miss, 10 invalidate
- bus_addr  out  ADDR_W  address of the operation
- bus_wb  out  1  with bus_valid: victim line was exclusive and is written back
- bus_wb_addr  out  ADDR_W  victim address {old tag, index}
- snoop_valid  in  1  another cache's bus operation
- snoop_op  in  2  encoding as bus_op
- snoop_addr  in  ADDR_W  snooped address
- snoop_wb  out  1  one-cycle pulse: write-back of own exclusive line due to snoop

Behaviour:
- Line states: invalid 00, exclusive 01, shared 10. Code 11 is never stored.
- Reset (asynchronous, reset_n=0):
  - All lines invalid; all tags 0; FSM in IDLE.
  - Every output 0.
  - Reset during REQ or ISSUE abandons the request; no bus_valid is produced.
- FSM states: IDLE, REQ, ISSUE, DONE.
- IDLE with cpu_valid: hit = (line state != invalid) and (tag match).
  - Read hit (shared or exclusive): go to DONE; cpu_hit=1; no state change.
  - Write hit, exclusive: go to DONE; cpu_hit=1.
  - Write hit, shared: latch op=invalidate; go to REQ.
  - Read miss: latch op=read_miss; go to REQ.
  - Write miss: latch op=write_miss; go to REQ.
  - On either miss, also latch wb = (victim line exclusive and tag differs) and the victim address.
- REQ:
  - bus_req=1, held until bus_grant=1 is sampled; then go to ISSUE.
  - Grant may arrive in the first REQ cycle.
- ISSUE (exactly one cycle): bus_req=0; bus_valid=1 with latched bus_op, bus_addr, bus_wb, bus_wb_addr. At the closing edge the line is updated:
  - read_miss: state shared, tag written.
  - write_miss: state exclusive, tag written.
  - invalidate: state exclusive.
  - Then go to DONE with cpu_hit=0.
- DONE: cpu_ready=1 for one cycle; cpu_hit as decided; then IDLE. The CPU must drop or change cpu_valid in the cycle after cpu_ready.
- Latency:
  - Hit: cpu_ready 2 cycles after cpu_valid is first sampled (IDLE, DONE).
  - Miss with immediate grant: bus_valid in cycle 3, cpu_ready in cycle 4.
- Snoop handling, every cycle, independent of FSM, only on a tag match with a non-invalid line:
  - write_miss or invalidate: line becomes invalid.
  - read_miss on exclusive: line becomes shared; snoop_wb=1 next cycle.
  - read_miss on shared: no change.
  - Non-matching or invalid lines: ignored.
- Snoop during own ISSUE cycle is ignored (own transaction).
- Snoop in REQ hitting the pending line:
  - If latched op=invalidate and the line is invalidated, op becomes write_miss.
  - If the victim line was exclusive and is downgraded or invalidated, latched wb is cleared.
- Simultaneous cpu_valid and snoop in IDLE: the snoop update applies first; hit is evaluated on the post-snoop state.
- Widths: bus_addr = cpu_addr latched at IDLE exit. bus_wb_addr = {stored tag, index}. No arithmetic wrap concerns.

Test Plan:
- Reset, read 0x04, grant immediate -> bus_valid with op=00, addr=0x04, wb=0; cpu_ready cycle 4, cpu_hit=0; line 0 shared.
- Write 0x04 after the read, grant after 3 cycles -> bus_req high 3 cycles, op=10; line exclusive; second write -> cpu_ready cycle 2, cpu_hit=1, no bus_valid.
- Line 0 exclusive tag 0x01, read 0x08 -> op=00, bus_wb=1, bus_wb_addr=0x04; line shared tag 0x02.
- Line 1 exclusive (0x05), snoop read_miss 0x05 -> snoop_wb pulse, line shared; snoop write_miss 0x05 -> invalid; next read 0x05 misses.
- Line shared, write issued, snoop invalidate same address while in REQ -> issued op=01 (write_miss), not 10.
- reset_n low during REQ -> bus_req 0 immediately, no bus_valid, all lines invalid.

Source files
------------

// File: rtl/msi_cpu_requester.sv
// CPU-side MSI snooping requester for a small direct-mapped cache.
// Turns CPU reads/writes into bus read_miss / write_miss / invalidate
// operations and keeps the per-line MSI state, including the effect of
// operations snooped from other caches.
module msi_cpu_requester #(
    parameter int LINES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wb,
    output logic [ADDR_W-1:0] bus_wb_addr,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_op,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_wb
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] ST_INV = 2'b00;
    localparam logic [1:0] ST_EXC = 2'b01;
    localparam logic [1:0] ST_SHR = 2'b10;

    localparam logic [1:0] OP_RM  = 2'b00;
    localparam logic [1:0] OP_WM  = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ISSUE = 2'b10,
        DONE  = 2'b11
    } fsm_t;

    fsm_t              fsm_r;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wb_r;
    logic [ADDR_W-1:0] wb_addr_r;

    logic [1:0]        line_state_r [LINES];
    logic [TAG_W-1:0]  line_tag_r   [LINES];

    // Line states after this cycle's snoop has been applied.
    logic [1:0]        snp_state_s  [LINES];
    logic              snoop_wb_set_s;

    logic [IDX_W-1:0]  snoop_idx_s;
    logic [TAG_W-1:0]  snoop_tag_s;
    logic [IDX_W-1:0]  cpu_idx_s;
    logic [TAG_W-1:0]  cpu_tag_s;
    logic [IDX_W-1:0]  pend_idx_s;

    logic [1:0]        cur_state_s;
    logic              tag_match_s;
    logic              hit_s;
    logic              victim_wb_s;
    logic [ADDR_W-1:0] victim_addr_s;
    logic [1:0]        pend_state_s;
    logic [1:0]        op_adj_s;
    logic              wb_adj_s;

    assign snoop_idx_s = snoop_addr[IDX_W-1:0];
    assign snoop_tag_s = snoop_addr[ADDR_W-1:IDX_W];
    assign cpu_idx_s   = cpu_addr[IDX_W-1:0];
    assign cpu_tag_s   = cpu_addr[ADDR_W-1:IDX_W];
    assign pend_idx_s  = addr_r[IDX_W-1:0];

    // Apply the snooped operation to a copy of the line states; our own
    // ISSUE cycle ignores snoops since the bus carries our transaction.
    always_comb begin
        for (int i = 0; i < LINES; i++) begin
            snp_state_s[i] = line_state_r[i];
        end
        snoop_wb_set_s = 1'b0;
        if (snoop_valid && (fsm_r != ISSUE) &&
            (line_state_r[snoop_idx_s] != ST_INV) &&
            (line_tag_r[snoop_idx_s] == snoop_tag_s)) begin
            case (snoop_op)
                OP_RM: begin
                    if (line_state_r[snoop_idx_s] == ST_EXC) begin
                        snp_state_s[snoop_idx_s] = ST_SHR;
                        snoop_wb_set_s           = 1'b1;
                    end else begin
                        snp_state_s[snoop_idx_s] = line_state_r[snoop_idx_s];
                    end
                end
                OP_WM, OP_INV: snp_state_s[snoop_idx_s] = ST_INV;
                default:       snp_state_s[snoop_idx_s] = line_state_r[snoop_idx_s];
            endcase
        end else begin
            snoop_wb_set_s = 1'b0;
        end
    end

    // Hit/victim evaluation for the CPU request on post-snoop state, and
    // adjustment of the pending operation when a snoop hits its line.
    always_comb begin
        cur_state_s   = snp_state_s[cpu_idx_s];
        tag_match_s   = (line_tag_r[cpu_idx_s] == cpu_tag_s);
        hit_s         = (cur_state_s != ST_INV) && tag_match_s;
        victim_wb_s   = (cur_state_s == ST_EXC) && !tag_match_s;
        victim_addr_s = {line_tag_r[cpu_idx_s], cpu_idx_s};
        pend_state_s  = snp_state_s[pend_idx_s];
        if ((op_r == OP_INV) && (pend_state_s == ST_INV)) begin
            op_adj_s = OP_WM;
        end else begin
            op_adj_s = op_r;
        end
        if (wb_r && (pend_state_s == ST_EXC)) begin
            wb_adj_s = 1'b1;
        end else begin
            wb_adj_s = 1'b0;
        end
    end

    // Request FSM with its latched operation and registered port outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_r       <= IDLE;
            op_r        <= OP_RM;
            addr_r      <= {ADDR_W{1'b0}};
            wb_r        <= 1'b0;
            wb_addr_r   <= {ADDR_W{1'b0}};
            cpu_ready   <= 1'b0;
            cpu_hit     <= 1'b0;
            bus_req     <= 1'b0;
            bus_valid   <= 1'b0;
            bus_op      <= 2'b00;
            bus_addr    <= {ADDR_W{1'b0}};
            bus_wb      <= 1'b0;
            bus_wb_addr <= {ADDR_W{1'b0}};
            snoop_wb    <= 1'b0;
        end else begin
            cpu_ready   <= 1'b0;
            cpu_hit     <= 1'b0;
            bus_req     <= 1'b0;
            bus_valid   <= 1'b0;
            bus_op      <= 2'b00;
            bus_addr    <= {ADDR_W{1'b0}};
            bus_wb      <= 1'b0;
            bus_wb_addr <= {ADDR_W{1'b0}};
            snoop_wb    <= snoop_wb_set_s;
            case (fsm_r)
                IDLE: begin
                    if (cpu_valid) begin
                        addr_r    <= cpu_addr;
                        wb_addr_r <= victim_addr_s;
                        if (hit_s && (!cpu_rw || (cur_state_s == ST_EXC))) begin
                            fsm_r     <= DONE;
                            cpu_ready <= 1'b1;
                            cpu_hit   <= 1'b1;
                        end else if (hit_s) begin
                            op_r    <= OP_INV;
                            wb_r    <= 1'b0;
                            bus_req <= 1'b1;
                            fsm_r   <= REQ;
                        end else begin
                            op_r    <= cpu_rw ? OP_WM : OP_RM;
                            wb_r    <= victim_wb_s;
                            bus_req <= 1'b1;
                            fsm_r   <= REQ;
                        end
                    end else begin
                        fsm_r <= IDLE;
                    end
                end
                REQ: begin
                    op_r <= op_adj_s;
                    wb_r <= wb_adj_s;
                    if (bus_grant) begin
                        fsm_r       <= ISSUE;
                        bus_valid   <= 1'b1;
                        bus_op      <= op_adj_s;
                        bus_addr    <= addr_r;
                        bus_wb      <= wb_adj_s;
                        bus_wb_addr <= wb_addr_r;
                    end else begin
                        bus_req <= 1'b1;
                        fsm_r   <= REQ;
                    end
                end
                ISSUE: begin
                    fsm_r     <= DONE;
                    cpu_ready <= 1'b1;
                    cpu_hit   <= 1'b0;
                end
                DONE: begin
                    fsm_r <= IDLE;
                end
                default: begin
                    fsm_r <= IDLE;
                end
            endcase
        end
    end

    // Line state/tag storage: snoop effects every cycle, own fill/upgrade
    // at the closing edge of ISSUE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LINES; i++) begin
                line_state_r[i] <= ST_INV;
                line_tag_r[i]   <= {TAG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                line_state_r[i] <= snp_state_s[i];
            end
            if (fsm_r == ISSUE) begin
                case (op_r)
                    OP_RM: begin
                        line_state_r[pend_idx_s] <= ST_SHR;
                        line_tag_r[pend_idx_s]   <= addr_r[ADDR_W-1:IDX_W];
                    end
                    OP_WM: begin
                        line_state_r[pend_idx_s] <= ST_EXC;
                        line_tag_r[pend_idx_s]   <= addr_r[ADDR_W-1:IDX_W];
                    end
                    OP_INV: begin
                        line_state_r[pend_idx_s] <= ST_EXC;
                    end
                    default: begin
                        line_state_r[pend_idx_s] <= snp_state_s[pend_idx_s];
                    end
                endcase
            end else begin
                line_state_r[pend_idx_s] <= snp_state_s[pend_idx_s];
            end
        end
    end

endmodule
